// File: rtl/color_mem_pkg.sv
// Shared types and constants for the color-plane memory sequencer.
package color_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Channel select encoding as decoded by the control unit
  localparam logic [1:0] RGB_R   = 2'b00;
  localparam logic [1:0] RGB_G   = 2'b01;
  localparam logic [1:0] RGB_B   = 2'b10;
  localparam logic [1:0] RGB_PIX = 2'b11;

  // Default plane base offsets for a 16-bit address space
  localparam logic [15:0] PLANE_R_DEF = 16'h0000;
  localparam logic [15:0] PLANE_G_DEF = 16'h4000;
  localparam logic [15:0] PLANE_B_DEF = 16'h8000;

  // Slice position (in DW units) of a plane inside a packed pixel word;
  // R occupies the highest slice, B the lowest.
  function automatic logic [1:0] beat_slice(input logic [1:0] beat);
    case (beat)
      RGB_R:   return 2'd2;
      RGB_G:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Plane base offset for a beat, given the three configured offsets
  function automatic logic [15:0] beat_offset(input logic [1:0]  beat,
                                              input logic [15:0] off_r,
                                              input logic [15:0] off_g,
                                              input logic [15:0] off_b);
    case (beat)
      RGB_R:   return off_r;
      RGB_G:   return off_g;
      default: return off_b;
    endcase
  endfunction

endpackage

// File: rtl/color_mem_sequencer_beat_timeout_counter.sv
// Per-beat wait counter: cleared at each beat start, counts cycles the
// memory holds off, and flags when the wait budget is exhausted.
module beat_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == CW'(TIMEOUT));
  assign o_term = w_term;

  // Wait counter; saturates at the terminal value until cleared
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/color_mem_sequencer.sv
// Multicycle sequencer between execute and the color-plane data memory.
// Single-channel accesses take one memory beat, full-pixel accesses take
// three (R, G, B); the pipeline is stalled until the access completes.
module color_mem_sequencer
  import color_mem_pkg::*;
#(
  parameter int           AW      = 16,
  parameter int           DW      = 8,
  parameter int           RW      = 32,
  parameter logic [AW-1:0] PLANE_R = AW'(PLANE_R_DEF),
  parameter logic [AW-1:0] PLANE_G = AW'(PLANE_G_DEF),
  parameter logic [AW-1:0] PLANE_B = AW'(PLANE_B_DEF),
  parameter int           TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic          MemWrite,
  input  logic [1:0]    RGB,
  input  logic [AW-1:0] Addr,
  input  logic [RW-1:0] WData,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic [RW-1:0] RData,
  output logic          rdata_valid,
  output logic          err,
  output logic          err_sticky
);

  state_t        r_state, w_next;

  logic          r_we;
  logic          r_pix;
  logic [1:0]    r_beat;
  logic [1:0]    r_last;
  logic          r_flush_pend;
  logic          r_abort;
  logic          r_err_sticky;
  logic [RW-1:0] r_rdata;
  logic [AW-1:0] r_addr;
  logic [RW-1:0] r_wdata;

  logic          w_accept;
  logic          w_beat_done;
  logic          w_timeout;
  logic          w_term;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic [1:0]    w_slice;
  logic [1:0]    w_dst;
  logic [AW-1:0] w_plane_off;

  assign w_slice     = beat_slice(r_beat);
  // Single-channel loads land in the lowest slice; pixels use plane order
  assign w_dst       = r_pix ? w_slice : 2'd0;
  assign w_plane_off = AW'(beat_offset(r_beat, 16'(PLANE_R), 16'(PLANE_G), 16'(PLANE_B)));

  // Counter restarts whenever a beat is not in progress or just finished
  assign w_cnt_clr = (r_state != ACCESS) || (mem_ready && !w_term);
  assign w_cnt_inc = (r_state == ACCESS) && !mem_ready;

  beat_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_term  (w_term)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and memory/pipeline handshake outputs
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    err         = 1'b0;
    rdata_valid = 1'b0;
    w_accept    = 1'b0;
    w_beat_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req && !flush) begin
          stall    = 1'b1;
          w_accept = 1'b1;
          w_next   = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (w_term) begin
          // Memory never answered: abandon the access
          err       = 1'b1;
          w_timeout = 1'b1;
          w_next    = DONE;
        end else begin
          mem_en    = 1'b1;
          mem_we    = r_we;
          mem_addr  = r_addr + w_plane_off;
          mem_wdata = r_wdata[int'(w_slice)*DW +: DW];
          if (mem_ready) begin
            w_beat_done = 1'b1;
            if ((r_beat == r_last) || r_flush_pend || flush) begin
              w_next = DONE;
            end
          end
        end
      end
      DONE: begin
        rdata_valid = !r_we && !r_abort;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Control state: beat sequencing, flush/abort tracking, load accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we         <= 1'b0;
      r_pix        <= 1'b0;
      r_beat       <= RGB_R;
      r_last       <= RGB_R;
      r_flush_pend <= 1'b0;
      r_abort      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_we         <= MemWrite;
        r_pix        <= (RGB == RGB_PIX);
        r_beat       <= (RGB == RGB_PIX) ? RGB_R : RGB;
        r_last       <= (RGB == RGB_PIX) ? RGB_B : RGB;
        r_flush_pend <= 1'b0;
        r_abort      <= 1'b0;
        r_rdata      <= '0;
      end
      if ((r_state == ACCESS) && flush) begin
        r_flush_pend <= 1'b1;
        r_abort      <= 1'b1;
      end
      if (w_beat_done) begin
        if (!r_we) begin
          r_rdata[int'(w_dst)*DW +: DW] <= mem_rdata;
        end
        r_beat <= r_beat + 2'd1;
      end
      if (w_timeout) begin
        r_rdata      <= '0;
        r_abort      <= 1'b1;
        r_err_sticky <= 1'b1;
      end
    end
  end

  // Captured address and store data; only meaningful while ACCESS
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= Addr;
      r_wdata <= WData;
    end
  end

  assign RData      = r_rdata;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_color_mem_sequencer.sv
// Directed bench for color_mem_sequencer: one task per scenario.
module tb_color_mem_sequencer;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        MemWrite;
  logic [1:0]  RGB;
  logic [15:0] Addr;
  logic [31:0] WData;
  logic        flush;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic [31:0] RData;
  logic        rdata_valid;
  logic        err;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  color_mem_sequencer #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .MemWrite    (MemWrite),
    .RGB         (RGB),
    .Addr        (Addr),
    .WData       (WData),
    .flush       (flush),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .RData       (RData),
    .rdata_valid (rdata_valid),
    .err         (err),
    .err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the next cycle's drive point; outputs are checked #1 later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_req = 1'b0; MemWrite = 1'b0; RGB = 2'b00; Addr = 16'h0;
    WData = 32'h0; flush = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    checks++;
    if ({mem_en, mem_we, stall, rdata_valid, err, err_sticky} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {mem_en, mem_we, stall, rdata_valid, err, err_sticky});
    end
    checks++;
    if ({RData, mem_addr, mem_wdata} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0/0/0", RData, mem_addr, mem_wdata);
    end
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_single_load();
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b0; RGB = 2'b01; Addr = 16'h0010;
    mem_ready = 1'b1; mem_rdata = 8'hA5;
    #1;
    checks++;
    if ({stall, mem_en} !== 2'b10) begin
      errors++; $display("FAIL single_req stall/en got %b want 10", {stall, mem_en});
    end
    next_cycle();
    mem_req = 1'b0;
    #1;
    checks++;
    if ({stall, mem_en, mem_we, mem_addr} !== {3'b110, 16'h4010}) begin
      errors++;
      $display("FAIL single_access got st=%b en=%b we=%b a=%h want 1 1 0 4010", stall, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    #1;
    checks++;
    if ({stall, mem_en, rdata_valid, RData} !== {3'b001, 32'h000000A5}) begin
      errors++;
      $display("FAIL single_done got st=%b en=%b v=%b d=%h want 0 0 1 000000a5", stall, mem_en, rdata_valid, RData);
    end
    next_cycle();
    #1;
    checks++;
    if (rdata_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_pulse got %b want 0", rdata_valid);
    end
  endtask

  task automatic test_pixel_load();
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b0; RGB = 2'b11; Addr = 16'h0002;
    mem_ready = 1'b1; mem_rdata = 8'h11;
    next_cycle();
    mem_req = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0002}) begin
      errors++; $display("FAIL pix_r got en=%b a=%h want 1 0002", mem_en, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_ready = (i == 2); mem_rdata = 8'h22;
      #1;
      checks++;
      if ({stall, mem_en, mem_addr} !== {2'b11, 16'h4002}) begin
        errors++;
        $display("FAIL pix_g_hold%0d got st=%b en=%b a=%h want 1 1 4002", i, stall, mem_en, mem_addr);
      end
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 8'h33;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h8002}) begin
      errors++; $display("FAIL pix_b got en=%b a=%h want 1 8002", mem_en, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({stall, rdata_valid, RData} !== {2'b01, 32'h00112233}) begin
      errors++;
      $display("FAIL pix_done got st=%b v=%b d=%h want 0 1 00112233", stall, rdata_valid, RData);
    end
  endtask

  task automatic test_pixel_store();
    logic [15:0] exp_a [3];
    logic [7:0]  exp_d [3];
    exp_a[0] = 16'h000A; exp_a[1] = 16'h400A; exp_a[2] = 16'h800A;
    exp_d[0] = 8'hCA;    exp_d[1] = 8'hFE;    exp_d[2] = 8'h01;
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b1; RGB = 2'b11; Addr = 16'h000A;
    WData = 32'h00CAFE01; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_req = 1'b0; WData = 32'h0;
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, exp_a[i], exp_d[i]}) begin
        errors++;
        $display("FAIL store_beat%0d got en=%b we=%b a=%h d=%h want 1 1 %h %h",
                 i, mem_en, mem_we, mem_addr, mem_wdata, exp_a[i], exp_d[i]);
      end
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({stall, mem_en, rdata_valid} !== 3'b000) begin
      errors++; $display("FAIL store_done got st/en/v=%b want 000", {stall, mem_en, rdata_valid});
    end
  endtask

  task automatic test_addr_wrap();
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b0; RGB = 2'b10; Addr = 16'hFFFF;
    mem_ready = 1'b1; mem_rdata = 8'h5C;
    next_cycle();
    mem_req = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 16'h7FFF) begin
      errors++; $display("FAIL wrap_addr got %h want 7fff", mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({rdata_valid, RData} !== {1'b1, 32'h0000005C}) begin
      errors++; $display("FAIL wrap_data got v=%b d=%h want 1 0000005c", rdata_valid, RData);
    end
  endtask

  task automatic test_timeout();
    int en_cycles;
    int err_cycles;
    en_cycles = 0;
    err_cycles = 0;
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b0; RGB = 2'b11; Addr = 16'h0000;
    mem_ready = 1'b1; mem_rdata = 8'h77;
    next_cycle();
    mem_req = 1'b0;
    // R beat completes, then G never answers
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mem_ready = 1'b0;
      #1;
      if (mem_en) en_cycles++;
      if (err) err_cycles++;
    end
    checks++;
    if (en_cycles !== 4) begin
      errors++; $display("FAIL timeout_wait_cycles got %0d want 4", en_cycles);
    end
    checks++;
    if ({err, stall, mem_en} !== 3'b110) begin
      errors++; $display("FAIL timeout_err got err/st/en=%b want 110", {err, stall, mem_en});
    end
    next_cycle();
    #1;
    if (err) err_cycles++;
    checks++;
    if ({stall, rdata_valid, err_sticky, RData} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL timeout_done got st=%b v=%b es=%b d=%h want 0 0 1 00000000", stall, rdata_valid, err_sticky, RData);
    end
    checks++;
    if (err_cycles !== 1) begin
      errors++; $display("FAIL timeout_err_pulse got %0d want 1", err_cycles);
    end
  endtask

  task automatic test_flush_and_reset();
    next_cycle();
    mem_req = 1'b1; MemWrite = 1'b0; RGB = 2'b11; Addr = 16'h0002;
    mem_ready = 1'b1; mem_rdata = 8'h11;
    next_cycle();
    mem_req = 1'b0;
    next_cycle();
    flush = 1'b1; mem_ready = 1'b0;
    next_cycle();
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h22;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h4002}) begin
      errors++; $display("FAIL flush_g_held got en=%b a=%h want 1 4002", mem_en, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_en, stall, rdata_valid} !== 3'b000) begin
      errors++; $display("FAIL flush_done got en/st/v=%b want 000", {mem_en, stall, rdata_valid});
    end
    next_cycle();
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL flush_no_b got en=%b want 0", mem_en);
    end
    // flush and request together in IDLE: flush wins
    next_cycle();
    mem_req = 1'b1; flush = 1'b1; RGB = 2'b00;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL idle_flush_stall got %b want 0", stall);
    end
    next_cycle();
    mem_req = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL idle_flush_noaccess got %b want 0", mem_en);
    end
    // asynchronous reset in the middle of a beat
    next_cycle();
    mem_req = 1'b1; RGB = 2'b01; Addr = 16'h0033;
    next_cycle();
    mem_req = 1'b0;
    #1;
    checks++;
    if ({mem_en, err_sticky} !== 2'b11) begin
      errors++; $display("FAIL pre_reset got en/es=%b want 11", {mem_en, err_sticky});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, stall, rdata_valid, err, err_sticky, mem_addr, mem_wdata, RData} !== 62'h0) begin
      errors++;
      $display("FAIL async_reset got en=%b st=%b es=%b a=%h d=%h r=%h want all 0",
               mem_en, stall, err_sticky, mem_addr, mem_wdata, RData);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    #1;
    checks++;
    if ({mem_en, stall} !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle got en/st=%b want 00", {mem_en, stall});
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_pixel_load();
    test_pixel_store();
    test_addr_wrap();
    test_timeout();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_mem_sequencer.md
Name: color_mem_sequencer

Overview:
- Multicycle sequencer between the execute stage and the color-plane data memory.
- Takes a memory instruction already decoded by the control unit (MemWrite, RGB channel select, address, store data) and drives a ready/enable memory handshake.
- A single-channel access (R, G or B) takes 1 beat; a full-pixel access (RGB=11) takes 3 sequential beats, one per plane.
- Stalls the pipeline until the access completes, then returns load data packed into a register-width word.

Parameters:
- AW, 16, memory address width
- DW, 8, channel (plane) data width
- RW, 32, register/result width; must be >= 3*DW
- PLANE_R, 16'h0000, base offset of R plane
- PLANE_G, 16'h4000, base offset of G plane
- PLANE_B, 16'h8000, base offset of B plane
- TIMEOUT, 255, max cycles a beat waits for mem_ready

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mem_req  in  1  execute stage holds a load/store
- MemWrite  in  1  1=store, 0=load
- RGB  in  2  00=R, 01=G, 10=B, 11=full pixel
- Addr  in  AW  pixel address (plane-relative)
- WData  in  RW  store data
- flush  in  1  pipeline flush
- mem_en  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completes current beat
- stall  out  1  freeze fetch/decode/execute
- RData  out  RW  packed load result
- rdata_valid  out  1  one-cycle pulse with RData
- err  out  1  one-cycle pulse on timeout
- err_sticky  out  1  set on any timeout, cleared only by reset

Behaviour:
- Reset (rst=0, async): state=IDLE. mem_en, mem_we, stall, rdata_valid, err and err_sticky are 0. RData and mem_addr/mem_wdata are 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On mem_req=1 and flush=0: capture MemWrite, RGB, Addr and WData. Set beat index from RGB (single channel: that plane only; 11: R, then G, then B). Clear the RData accumulator. Go to ACCESS.
  - stall = mem_req & ~flush, combinationally, in this cycle.
- ACCESS:
  - mem_en=1 and stall=1.
  - mem_addr = Addr + PLANE_x, truncated mod 2^AW (wrap allowed).
  - mem_we = captured MemWrite.
  - mem_wdata = WData[23:16] for R, [15:8] for G, [7:0] for B. Shift by DW in general: R at the highest slice.
  - Handshake: mem_en and all memory outputs held stable until mem_ready=1. A beat completes in the cycle mem_ready=1.
  - On load completion, mem_rdata is written into the corresponding RData slice. For a single channel the result lands in [DW-1:0], zero-extended. For a pixel it is {R,G,B} zero-extended.
  - Last beat done: go to DONE. Otherwise advance the beat and stay in ACCESS, with mem_en still 1 (back-to-back beats allowed).
- DONE:
  - stall=0 for one cycle.
  - rdata_valid=1 for loads; 0 for stores, timeouts and flushed ops.
  - Always returns to IDLE. mem_req is not sampled in DONE.
- Timeout:
  - A per-beat counter resets at each beat start and increments each ACCESS cycle with mem_ready=0.
  - When it reaches TIMEOUT: drop mem_en, pulse err, set err_sticky, clear RData to 0, go to DONE (rdata_valid=0).
- Flush during ACCESS:
  - Latched as flush_pend. The current beat still completes (no mem_en withdrawal mid-beat).
  - Remaining beats are skipped and the FSM goes to DONE with rdata_valid=0.
  - Stores already committed are not undone.
- Flush and mem_req both in IDLE: the flush wins; no access, stall=0.
- Latency:
  - Single-channel, zero-wait memory: req cycle, 1 ACCESS cycle, DONE = 3 cycles.
  - Pixel: 5 cycles.
  - Each mem_ready wait cycle adds 1.
- Reset mid-ACCESS: immediate return to IDLE with all outputs at reset values. Any partial store is left as is.

Decomposition:
- color_mem_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - RGB encoding constants (RGB_R=2'b00, RGB_G=2'b01, RGB_B=2'b10, RGB_PIX=2'b11)
  - default plane offsets
  - helper function mapping beat index to plane offset and data slice
- One sub-module, beat_timeout_counter: load/clear/increment with a terminal flag at TIMEOUT.

Test Plan:
- Load RGB=01, Addr=16'h0010, zero-wait, mem_rdata=8'hA5 -> mem_addr=16'h4010 for 1 cycle; stall high 2 cycles; RData=32'h000000A5 with rdata_valid on cycle 3.
- Pixel load Addr=16'h0002, rdata R=11, G=22, B=33, mem_ready delayed 2 cycles on G -> addresses 0002/4002/8002 in order; mem_en/addr stable while waiting; RData=32'h00112233; total 7 cycles.
- Pixel store WData=32'h00CAFE01 -> three writes CA@0x0000+A, FE@0x4000+A, 01@0x8000+A; rdata_valid never asserted.
- Addr=16'hFFFF, RGB=10 -> mem_addr=16'h7FFF (wraps mod 2^16).
- mem_ready held 0 with TIMEOUT=4 -> mem_en drops after 4 wait cycles; err pulses once; err_sticky=1; RData=0; stall released.
- flush during G beat of a pixel load -> G beat completes on mem_ready, B beat never issued, rdata_valid=0. Then deassert rst mid-ACCESS -> all outputs 0 asynchronously.
